// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: the machine word width, major opcode
// encodings, the canonical NOP and the fetch sequencer state encoding.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPCODE_R      = 7'b0110011;
   localparam logic [6:0] OPCODE_I      = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } fetch_state_t;

   function automatic logic [6:0] opcode_of(input logic [31:0] word);
      return word[6:0];
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one request outstanding to
// instruction memory and holds each fetched word until decode takes it.
module instr_fetch_unit #(
   parameter int unsigned XLEN               = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misaligned
);
   import riscv_pkg::*;

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] pc;
   logic            drop;
   logic            req_valid_q;
   logic            req_fire;
   logic            rsp_take;
   logic            hold_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_REQ;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_REQ: begin
            if (req_fire) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_next = (drop || redirect_valid) ? S_REQ : S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid || instr_ready) begin
               state_next = S_REQ;
            end
         end
         default: state_next = S_REQ;
      endcase
   end

   // The request strobe is a flop, so acceptance is qualified by it rather than by state alone.
   always_comb begin
      imem_req_valid = req_valid_q;
      imem_req_addr  = pc;
      req_fire       = (state == S_REQ) && req_valid_q && imem_req_ready;
      rsp_take       = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;
      hold_fire      = (state == S_HOLD) && instr_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         drop        <= 1'b0;
         req_valid_q <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= NOP_INSTR;
         instr_pc    <= '0;
         misaligned  <= 1'b0;
      end else begin
         req_valid_q <= (state_next == S_REQ);
         if (redirect_valid) begin
            pc          <= {redirect_pc[XLEN-1:2], 2'b00};
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            if (redirect_pc[1:0] != 2'b00) begin
               misaligned <= 1'b1;
            end
            // A request already in flight (or accepted this cycle) must have its word thrown away.
            drop <= req_fire || ((state == S_WAIT) && !imem_rsp_valid);
         end else begin
            if ((state == S_WAIT) && imem_rsp_valid) begin
               drop <= 1'b0;
            end
            if (rsp_take) begin
               instr       <= imem_rsp_data;
               instr_pc    <= pc;
               instr_valid <= 1'b1;
               pc          <= pc + XLEN'(4);
            end
            if (hold_fire) begin
               instr_valid <= 1'b0;
               instr       <= NOP_INSTR;
            end
         end
      end
   end

   a_rsp_only_in_wait : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (state == S_WAIT));

   a_req_only_in_req : assert property (@(posedge clk) disable iff (rst)
      imem_req_valid |-> (state == S_REQ));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch front end that supplies instruction words, and therefore the opcode field, to the decode/control path. It is the producing end of the decoder's opcode interface. It holds the PC and issues single-outstanding requests to instruction memory over a valid/ready request and valid response interface. It presents each fetched word to decode with a valid/ready handshake and accepts branch redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address and instruction width
NOP_INSTR, 32'h0000_0013, value driven on instr while not valid (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  word-aligned fetch address
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response word valid (one per accepted request, any latency >=1)
imem_rsp_data  in  XLEN  instruction word
instr_valid  out  1  instr/instr_pc valid to decode
instr_ready  in  1  decode consumes instr
instr  out  XLEN  instruction word (opcode = instr[6:0])
instr_pc  out  XLEN  PC of instr
redirect_valid  in  1  branch taken / PC redirect from execute
redirect_pc  in  XLEN  redirect target
misaligned  out  1  sticky: a redirect target had [1:0] != 0

Behaviour:
- Reset state:
  - pc=RESET_PC, state=S_REQ, drop=0
  - imem_req_valid=0 in the reset cycle; it is registered-out and asserts on the first cycle after rst deasserts
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0, misaligned=0
- Every register obeys rst, including mid-transaction. A response arriving after reset for a pre-reset request is ignored, because a post-reset S_REQ has not yet been accepted.
- States:
  - S_REQ:
    - imem_req_valid=1, imem_req_addr=pc
    - imem_req_ready=1 -> S_WAIT
  - S_WAIT:
    - imem_req_valid=0
    - imem_rsp_valid & drop -> discard, drop<=0, S_REQ
    - imem_rsp_valid & !drop -> instr<=rsp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, S_HOLD
  - S_HOLD:
    - instr_valid=1, stable until handshake
    - instr_valid & instr_ready -> instr_valid<=0, instr<=NOP_INSTR, S_REQ
- Latency and throughput:
  - Minimum latency from request acceptance to instr_valid is rsp latency +1 cycle.
  - Peak throughput is one instruction per 3 cycles with 1-cycle memory.
- Redirect (highest priority, any state):
  - pc<=redirect_pc & ~3. misaligned<=1 if redirect_pc[1:0]!=0 (sticky until rst).
  - instr_valid<=0, instr<=NOP_INSTR. A concurrent instr_ready is ignored and the held word is flushed.
  - In S_REQ with imem_req_ready=1 the same cycle: the old request is accepted, so drop<=1 and go to S_WAIT. The response is discarded, then the new pc is requested.
  - In S_REQ without ready: stay in S_REQ. The new address appears the next cycle, and an unaccepted request may change address.
  - In S_WAIT without rsp_valid: drop<=1, stay in S_WAIT.
  - In S_WAIT with rsp_valid the same cycle: discard the response, go to S_REQ with drop=0.
  - In S_HOLD: go to S_REQ.
- pc arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0.
- At most one outstanding request; imem_req_valid is never high in S_WAIT or S_HOLD.
- imem_rsp_valid in S_REQ or S_HOLD is a protocol violation. It is ignored, and a simulation assertion fires.

Decomposition:
- Shared package (riscv_pkg): XLEN, OPCODE_* constants (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011), NOP_INSTR, fetch state enum {S_REQ,S_WAIT,S_HOLD}.
- Single module. No sub-module is warranted. The PC register and the output holding register are local.

Test Plan:
- Reset then 1-cycle memory returning 32'h0000_0033 and 32'h0040_0093 -> instr_pc 0 then 4, instr matches in order, instr_valid seen once per word, imem_req_addr 0,4,8.
- Decode backpressure: instr_ready=0 for 5 cycles -> instr and instr_pc stable, no new imem_req_valid; ready=1 -> next request addr=pc+4.
- Redirect while in S_WAIT (rsp latency 3) to 32'h100 -> stale response discarded, next request addr 32'h100, first instr_pc=32'h100.
- Redirect in S_HOLD coincident with instr_ready to 32'h200 -> held word flushed, instr_valid low next cycle, fetch resumes at 32'h200.
- Redirect to 32'h0000_0106 -> misaligned=1 stays set, fetch addr 32'h104; rst clears misaligned and pc=RESET_PC.
- Wrap: redirect to 32'hFFFF_FFFC, return word -> next request addr 32'h0000_0000; assert rst during S_WAIT -> late response ignored, instr_valid stays 0.
